// File: rtl/dp_lt_pkg.sv
// rtl/dp_lt_pkg.sv - shared types, codes and lane-mask helper for link training
package dp_lt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CR      = 2'd1,
        EQ      = 2'd2,
        ALIGNED = 2'd3
    } state_t;

    localparam logic [7:0] BW_RBR  = 8'h06;
    localparam logic [7:0] BW_HBR  = 8'h0A;
    localparam logic [7:0] BW_HBR2 = 8'h14;
    localparam logic [7:0] BW_HBR3 = 8'h1E;

    localparam logic [1:0] LC_1       = 2'b00;
    localparam logic [1:0] LC_2       = 2'b01;
    localparam logic [1:0] LC_ILLEGAL = 2'b10;
    localparam logic [1:0] LC_4       = 2'b11;

    localparam logic [1:0] TPS_NONE = 2'b00;
    localparam logic [1:0] TPS_1    = 2'b01;
    localparam logic [1:0] TPS_2    = 2'b10;
    localparam logic [1:0] TPS_3    = 2'b11;

    // Lane-count code to per-lane enable mask; the illegal code enables nothing.
    function automatic logic [3:0] lc2mask(input logic [1:0] lc);
        logic [3:0] m;
        case (lc)
            LC_1:    m = 4'b0001;
            LC_2:    m = 4'b0011;
            LC_4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lt_lane_lock_filter.sv
// rtl/lt_lane_lock_filter.sv - saturating consecutive-high filter for one PHY lock flag
module lt_lane_lock_filter #(
    parameter int LOCK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flag,
    output logic o_stable
);

    localparam int CW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(LOCK_CYCLES);

    logic [CW-1:0] r_cnt;

    // Count consecutive high cycles, saturate at LOCK_CYCLES, restart on any low cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (!i_flag)
            r_cnt <= '0;
        else if (r_cnt != SAT)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_stable = (r_cnt == SAT);

endmodule

// File: rtl/lt_sink_responder.sv
// rtl/lt_sink_responder.sv - sink-side DP link-training CR/EQ status and adjust responder
module lt_sink_responder
    import dp_lt_pkg::*;
#(
    parameter int         LOCK_CYCLES  = 4,
    parameter int         ADJ_INTERVAL = 8,
    parameter logic [7:0] MAX_BW       = 8'h1E,
    parameter logic [1:0] MAX_LC       = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tps_vld,
    input  logic [1:0] tps_sel,
    input  logic [7:0] link_bw,
    input  logic [1:0] lane_cnt,
    input  logic       lane_set_vld,
    input  logic [7:0] lane_set_vs,
    input  logic [7:0] lane_set_pe,
    input  logic [3:0] phy_cdr_lock,
    input  logic [3:0] phy_sym_lock,
    output logic [3:0] cr_done,
    output logic [3:0] eq_done,
    output logic       align_done,
    output logic [7:0] adj_vs,
    output logic [7:0] adj_pe,
    output logic       status_vld
);

    localparam int IW = (ADJ_INTERVAL > 1) ? $clog2(ADJ_INTERVAL) : 1;
    localparam logic [IW-1:0] IVL_TERM = IW'(ADJ_INTERVAL - 1);

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_bw, r_vs, r_pe;
    logic [1:0]    r_lc;
    logic [IW-1:0] r_ivl_cnt, w_ivl_nxt;
    logic [3:0]    r_cr_done, r_eq_done, w_cr_nxt, w_eq_nxt;
    logic          r_align_done, r_status_vld, w_align_nxt, w_status_nxt;
    logic [7:0]    r_adj_vs, r_adj_pe, w_adj_vs_nxt, w_adj_pe_nxt;

    logic [3:0] w_cdr_stable, w_sym_stable, w_mask, w_cdr_lost, w_sym_lost;
    logic       w_supported, w_tick;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_lane
        lt_lane_lock_filter #(.LOCK_CYCLES(LOCK_CYCLES)) u_cdr_filt (
            .clk(clk), .rst_n(rst_n), .i_flag(phy_cdr_lock[g]), .o_stable(w_cdr_stable[g])
        );
        lt_lane_lock_filter #(.LOCK_CYCLES(LOCK_CYCLES)) u_sym_filt (
            .clk(clk), .rst_n(rst_n), .i_flag(phy_sym_lock[g]), .o_stable(w_sym_stable[g])
        );
    end

    assign w_supported = (r_bw == BW_RBR || r_bw == BW_HBR || r_bw == BW_HBR2 || r_bw == BW_HBR3)
                      && (r_bw <= MAX_BW) && (r_lc != LC_ILLEGAL) && (r_lc <= MAX_LC);
    assign w_mask      = w_supported ? lc2mask(r_lc) : 4'b0000;
    assign w_cdr_lost  = w_mask & ~phy_cdr_lock;
    assign w_sym_lost  = w_mask & ~phy_sym_lock;
    // A fresh TPS or lane-set write restarts the interval, so it also swallows a tick.
    assign w_tick      = (r_state == CR || r_state == EQ) && (r_ivl_cnt == IVL_TERM)
                      && !tps_vld && !lane_set_vld;

    // Capture link config on TPS writes and drive settings on lane-set writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bw <= '0;
            r_lc <= '0;
            r_vs <= '0;
            r_pe <= '0;
        end else begin
            if (tps_vld) begin
                r_bw <= link_bw;
                r_lc <= lane_cnt;
            end
            if (lane_set_vld) begin
                r_vs <= lane_set_vs;
                r_pe <= lane_set_pe;
            end
        end
    end

    // State, interval counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ivl_cnt    <= '0;
            r_cr_done    <= '0;
            r_eq_done    <= '0;
            r_align_done <= 1'b0;
            r_adj_vs     <= '0;
            r_adj_pe     <= '0;
            r_status_vld <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ivl_cnt    <= w_ivl_nxt;
            r_cr_done    <= w_cr_nxt;
            r_eq_done    <= w_eq_nxt;
            r_align_done <= w_align_nxt;
            r_adj_vs     <= w_adj_vs_nxt;
            r_adj_pe     <= w_adj_pe_nxt;
            r_status_vld <= w_status_nxt;
        end
    end

    // Next state and next outputs: per-state tick evaluation, then TPS writes override.
    always_comb begin
        w_state_nxt  = r_state;
        w_cr_nxt     = r_cr_done;
        w_eq_nxt     = r_eq_done;
        w_align_nxt  = r_align_done;
        w_adj_vs_nxt = r_adj_vs;
        w_adj_pe_nxt = r_adj_pe;
        w_status_nxt = 1'b0;

        if (tps_vld || lane_set_vld)
            w_ivl_nxt = '0;
        else if (r_state == CR || r_state == EQ)
            w_ivl_nxt = (r_ivl_cnt == IVL_TERM) ? '0 : r_ivl_cnt + 1'b1;
        else
            w_ivl_nxt = '0;

        case (r_state)
            CR: begin
                if (w_tick) begin
                    w_cr_nxt     = w_cdr_stable & w_mask;
                    w_adj_pe_nxt = r_pe;
                    w_status_nxt = 1'b1;
                    for (int l = 0; l < 4; l++) begin
                        if (w_mask[l] && !w_cdr_stable[l] && r_vs[2*l +: 2] != 2'd3)
                            w_adj_vs_nxt[2*l +: 2] = r_vs[2*l +: 2] + 2'd1;
                        else
                            w_adj_vs_nxt[2*l +: 2] = r_vs[2*l +: 2];
                    end
                end
            end
            EQ: begin
                if (w_tick) begin
                    w_cr_nxt     = w_cdr_stable & w_mask;
                    w_eq_nxt     = w_sym_stable & w_cr_nxt;
                    w_align_nxt  = (w_eq_nxt == w_mask) && (w_mask != 4'b0000);
                    w_adj_vs_nxt = r_vs;
                    w_status_nxt = 1'b1;
                    for (int l = 0; l < 4; l++) begin
                        if (w_mask[l] && !w_eq_nxt[l]
                            && ({1'b0, r_vs[2*l +: 2]} + {1'b0, r_pe[2*l +: 2]} + 3'd1) <= 3'd3)
                            w_adj_pe_nxt[2*l +: 2] = r_pe[2*l +: 2] + 2'd1;
                        else
                            w_adj_pe_nxt[2*l +: 2] = r_pe[2*l +: 2];
                    end
                end
            end
            ALIGNED: begin
                if ((w_cdr_lost | w_sym_lost) != 4'b0000) begin
                    w_cr_nxt     = r_cr_done & ~w_cdr_lost;
                    w_eq_nxt     = r_eq_done & ~(w_cdr_lost | w_sym_lost);
                    w_align_nxt  = 1'b0;
                    w_status_nxt = 1'b1;
                    w_state_nxt  = EQ;
                end
            end
            default: ;
        endcase

        if (tps_vld) begin
            case (tps_sel)
                TPS_1: begin
                    w_state_nxt  = CR;
                    w_cr_nxt     = '0;
                    w_eq_nxt     = '0;
                    w_align_nxt  = 1'b0;
                    w_adj_vs_nxt = '0;
                    w_adj_pe_nxt = '0;
                    w_status_nxt = 1'b0;
                end
                TPS_2, TPS_3: begin
                    w_state_nxt = EQ;
                end
                default: begin
                    if (r_align_done) begin
                        w_state_nxt = ALIGNED;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_cr_nxt     = '0;
                        w_eq_nxt     = '0;
                        w_align_nxt  = 1'b0;
                        w_adj_vs_nxt = '0;
                        w_adj_pe_nxt = '0;
                        w_status_nxt = 1'b0;
                    end
                end
            endcase
        end
    end

    assign cr_done    = r_cr_done;
    assign eq_done    = r_eq_done;
    assign align_done = r_align_done;
    assign adj_vs     = r_adj_vs;
    assign adj_pe     = r_adj_pe;
    assign status_vld = r_status_vld;

endmodule

// File: tb/tb_lt_sink_responder.sv
// tb/tb_lt_sink_responder.sv - directed self-checking bench for lt_sink_responder
module tb_lt_sink_responder;
    import dp_lt_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tps_vld = 1'b0;
    logic [1:0] tps_sel = 2'b00;
    logic [7:0] link_bw = 8'h00;
    logic [1:0] lane_cnt = 2'b00;
    logic       lane_set_vld = 1'b0;
    logic [7:0] lane_set_vs = 8'h00;
    logic [7:0] lane_set_pe = 8'h00;
    logic [3:0] phy_cdr_lock = 4'h0;
    logic [3:0] phy_sym_lock = 4'h0;
    logic [3:0] cr_done, eq_done;
    logic       align_done, status_vld;
    logic [7:0] adj_vs, adj_pe;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int seen;

    lt_sink_responder dut (
        .clk(clk), .rst_n(rst_n), .tps_vld(tps_vld), .tps_sel(tps_sel),
        .link_bw(link_bw), .lane_cnt(lane_cnt), .lane_set_vld(lane_set_vld),
        .lane_set_vs(lane_set_vs), .lane_set_pe(lane_set_pe),
        .phy_cdr_lock(phy_cdr_lock), .phy_sym_lock(phy_sym_lock),
        .cr_done(cr_done), .eq_done(eq_done), .align_done(align_done),
        .adj_vs(adj_vs), .adj_pe(adj_pe), .status_vld(status_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_tps(input logic [1:0] sel, input logic [7:0] bw, input logic [1:0] lc,
                          input logic ls, input logic [7:0] vs, input logic [7:0] pe);
        @(posedge clk); #1;
        tps_vld = 1'b1; tps_sel = sel; link_bw = bw; lane_cnt = lc;
        lane_set_vld = ls; lane_set_vs = vs; lane_set_pe = pe;
        @(posedge clk); #1;
        tps_vld = 1'b0; lane_set_vld = 1'b0;
    endtask

    task automatic do_lane_set(input logic [7:0] vs, input logic [7:0] pe);
        @(posedge clk); #1;
        lane_set_vld = 1'b1; lane_set_vs = vs; lane_set_pe = pe;
        @(posedge clk); #1;
        lane_set_vld = 1'b0;
    endtask

    task automatic wait_status(input string tag, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (status_vld) break;
        end
        chk(tag, 32'(status_vld), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", {cr_done, eq_done, 7'd0, align_done, adj_vs, adj_pe}, 32'd0);
        chk("rst_status", 32'(status_vld), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: CR, 2 lanes both locked
        phy_cdr_lock = 4'b0011; phy_sym_lock = 4'b0000;
        do_tps(TPS_1, 8'h14, 2'b01, 1'b1, 8'h05, 8'h00);
        wait_status("t1_status", lat);
        chk("t1_latency", 32'(lat), 32'd9);
        chk("t1_cr", 32'(cr_done), 32'h3);
        chk("t1_adj_vs", 32'(adj_vs), 32'h05);
        @(negedge clk);
        chk("t1_pulse_end", 32'(status_vld), 32'd0);

        // 2: lane1 cdr low, swing saturation then increment
        phy_cdr_lock = 4'b0001;
        do_lane_set(8'h0D, 8'h00);
        wait_status("t2a_status", lat);
        chk("t2a_cr", 32'(cr_done), 32'h1);
        chk("t2a_adj_vs", 32'(adj_vs), 32'h0D);
        do_lane_set(8'h05, 8'h00);
        wait_status("t2b_status", lat);
        chk("t2b_adj_vs", 32'(adj_vs), 32'h09);

        // 3: unsupported configurations never report CR
        phy_cdr_lock = 4'hF; phy_sym_lock = 4'hF;
        do_tps(TPS_1, 8'h19, 2'b11, 1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            wait_status("t3a_status", lat);
            chk("t3a_cr", 32'(cr_done), 32'h0);
        end
        do_tps(TPS_1, 8'h14, 2'b10, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            wait_status("t3b_status", lat);
            chk("t3b_cr", 32'(cr_done), 32'h0);
        end

        // 4: 4-lane EQ, ALIGNED, sym drop on lane2
        do_tps(TPS_1, 8'h0A, 2'b11, 1'b1, 8'h00, 8'h00);
        wait_status("t4_cr_status", lat);
        chk("t4_cr", 32'(cr_done), 32'hF);
        do_tps(TPS_2, 8'h0A, 2'b11, 1'b0, 8'h00, 8'h00);
        wait_status("t4_eq_status", lat);
        chk("t4_eq", 32'(eq_done), 32'hF);
        chk("t4_align", 32'(align_done), 32'd1);
        do_tps(TPS_NONE, 8'h0A, 2'b11, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        chk("t4_hold", {eq_done, 3'd0, align_done, 7'd0, status_vld}, {4'hF, 3'd0, 1'b1, 7'd0, 1'b0});
        chk("t4_state_al", 32'(dut.r_state), 32'(ALIGNED));
        @(posedge clk); #1 phy_sym_lock = 4'b1011;
        @(posedge clk); @(negedge clk);
        chk("t4_drop_eq", 32'(eq_done), 32'hB);
        chk("t4_drop_cr", 32'(cr_done), 32'hF);
        chk("t4_drop_align", 32'(align_done), 32'd0);
        chk("t4_drop_status", 32'(status_vld), 32'd1);
        chk("t4_state_eq", 32'(dut.r_state), 32'(EQ));
        wait_status("t4_retick_status", lat);
        chk("t4_retick_eq", 32'(eq_done), 32'hB);
        chk("t4_retick_pe", 32'(adj_pe), 32'h10);

        // 5: pre-emphasis limited by swing+pe budget
        phy_cdr_lock = 4'hF; phy_sym_lock = 4'b1110;
        do_tps(TPS_1, 8'h14, 2'b00, 1'b1, 8'h00, 8'h00);
        do_tps(TPS_2, 8'h14, 2'b00, 1'b1, 8'h02, 8'h01);
        wait_status("t5a_status", lat);
        chk("t5a_cr", 32'(cr_done), 32'h1);
        chk("t5a_eq", 32'(eq_done), 32'h0);
        chk("t5a_adj_pe", 32'(adj_pe), 32'h01);
        chk("t5a_adj_vs", 32'(adj_vs), 32'h02);
        do_lane_set(8'h01, 8'h01);
        wait_status("t5b_status", lat);
        chk("t5b_adj_pe", 32'(adj_pe), 32'h02);

        // 6: short cdr glitch is filtered; async reset mid-EQ
        phy_cdr_lock = 4'h0; phy_sym_lock = 4'h0;
        do_tps(TPS_1, 8'h06, 2'b00, 1'b1, 8'h00, 8'h00);
        phy_cdr_lock = 4'b0001;
        repeat (3) @(posedge clk);
        #1 phy_cdr_lock = 4'b0000;
        wait_status("t6_glitch_status", lat);
        chk("t6_glitch_cr", 32'(cr_done), 32'h0);
        chk("t6_glitch_vs", 32'(adj_vs), 32'h01);
        phy_cdr_lock = 4'hF; phy_sym_lock = 4'hF;
        do_tps(TPS_2, 8'h06, 2'b00, 1'b0, 8'h00, 8'h00);
        wait_status("t6_eq_status", lat);
        chk("t6_eq_pre", {cr_done, eq_done, 7'd0, align_done}, {4'h1, 4'h1, 7'd0, 1'b1});
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {cr_done, eq_done, 7'd0, align_done, adj_vs, adj_pe}, 32'd0);
        chk("t6_rst_status", 32'(status_vld), 32'd0);
        chk("t6_rst_state", 32'(dut.r_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (status_vld) seen++;
        end
        chk("t6_no_pending_tick", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
